// File: rtl/pm_load_pkg.sv
// pm_load_pkg
// Shared definitions for the program-memory load controller:
//   - default values for the controller parameters
//   - the controller state encoding
//   - a helper that sizes the shared idle/hold down-counter
package pm_load_pkg;

    localparam int unsigned PM_ADD_WIDTH = 7;
    localparam int unsigned PM_WIDTH     = 8;
    localparam int unsigned PM_TIMEOUT   = 255;
    localparam int unsigned PM_RST_HOLD  = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RELEASE,
        ST_RUN,
        ST_ERROR
    } pm_state_t;

    // Counter width large enough to hold the larger of the two reload counts.
    function automatic int unsigned pm_timer_width(input int unsigned a, input int unsigned b);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/pm_load_timer.sv
// pm_load_timer
// Loadable down-counter that saturates at zero. Used by the load controller
// both as the inter-byte idle timeout and as the CPU-reset hold counter.
// Ports:
//   clk       - clock, rising edge
//   rst       - synchronous active-low reset (count cleared)
//   load      - load load_val this cycle (has priority over en)
//   load_val  - value to load
//   en        - decrement by one when non-zero
//   zero      - count is zero
module pm_load_timer #(
    parameter int unsigned CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          en,
    output logic          zero
);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/pm_load_controller.sv
// pm_load_controller
// Streams a block of bytes into program memory while holding the CPU in
// reset, then releases the CPU after a fixed hold time.
// Ports:
//   clk, rst            - clock (rising edge), synchronous active-low reset
//   load_start          - request a load (accepted in IDLE, RUN, ERROR)
//   load_len            - byte count captured on accept; 0 means 2^ADD_WIDTH
//   byte_in, byte_valid - incoming byte stream
//   byte_ready          - high while loading; a transfer is valid && ready
//   pm_wr_en, pm_addr,
//   pm_wr_data          - program-memory write port, one cycle after transfer
//   cpu_rst             - holds the CPU in reset (low only in RUN)
//   busy                - LOAD or RELEASE
//   done                - one-cycle pulse on entering RUN
//   err                 - sticky idle-timeout flag, cleared by a new load
module pm_load_controller
    import pm_load_pkg::*;
#(
    parameter int unsigned ADD_WIDTH = PM_ADD_WIDTH,
    parameter int unsigned WIDTH     = PM_WIDTH,
    parameter int unsigned TIMEOUT   = PM_TIMEOUT,
    parameter int unsigned RST_HOLD  = PM_RST_HOLD
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_start,
    input  logic [ADD_WIDTH-1:0] load_len,
    input  logic [WIDTH-1:0]     byte_in,
    input  logic                 byte_valid,
    output logic                 byte_ready,
    output logic                 pm_wr_en,
    output logic [ADD_WIDTH-1:0] pm_addr,
    output logic [WIDTH-1:0]     pm_wr_data,
    output logic                 cpu_rst,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    localparam int unsigned CW = pm_timer_width(TIMEOUT, RST_HOLD);

    // The timer is checked for zero before decrementing, so a reload of
    // N-1 gives exactly N cycles in the state (minimum one cycle).
    localparam logic [CW-1:0] TO_RELOAD   = CW'((TIMEOUT  > 0) ? TIMEOUT  - 1 : 0);
    localparam logic [CW-1:0] HOLD_RELOAD = CW'((RST_HOLD > 0) ? RST_HOLD - 1 : 0);

    pm_state_t            state;
    logic [ADD_WIDTH-1:0] count;
    logic [ADD_WIDTH-1:0] len_q;
    logic [ADD_WIDTH-1:0] cnt_next;
    logic                 xfer;
    logic                 last;
    logic                 accept;

    logic                 tmr_load;
    logic [CW-1:0]        tmr_val;
    logic                 tmr_en;
    logic                 tmr_zero;

    assign byte_ready = (state == ST_LOAD);
    assign busy       = (state == ST_LOAD) || (state == ST_RELEASE);
    assign xfer       = byte_valid && byte_ready;
    assign cnt_next   = count + 1'b1;
    // len 0 works naturally: the 2^ADD_WIDTH-th transfer wraps cnt_next to 0.
    assign last       = (cnt_next == len_q);
    assign accept     = load_start &&
                        ((state == ST_IDLE) || (state == ST_RUN) || (state == ST_ERROR));

    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = '0;
        tmr_en   = 1'b0;
        if (accept) begin
            tmr_load = 1'b1;
            tmr_val  = TO_RELOAD;
        end else if (state == ST_LOAD) begin
            if (xfer) begin
                tmr_load = 1'b1;
                tmr_val  = last ? HOLD_RELOAD : TO_RELOAD;
            end else begin
                tmr_en = 1'b1;
            end
        end else if (state == ST_RELEASE) begin
            tmr_en = 1'b1;
        end
    end

    pm_load_timer #(
        .CW(CW)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .en       (tmr_en),
        .zero     (tmr_zero)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= ST_IDLE;
            count      <= '0;
            len_q      <= '0;
            pm_addr    <= '0;
            pm_wr_data <= '0;
            pm_wr_en   <= 1'b0;
            cpu_rst    <= 1'b1;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            pm_wr_en <= 1'b0;
            done     <= 1'b0;
            case (state)
                ST_IDLE, ST_RUN, ST_ERROR: begin
                    if (load_start) begin
                        state   <= ST_LOAD;
                        len_q   <= load_len;
                        count   <= '0;
                        pm_addr <= '0;
                        err     <= 1'b0;
                        cpu_rst <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (xfer) begin
                        pm_wr_en   <= 1'b1;
                        pm_wr_data <= byte_in;
                        pm_addr    <= count;
                        count      <= cnt_next;
                        if (last) begin
                            state <= ST_RELEASE;
                        end
                    end else if (tmr_zero) begin
                        state <= ST_ERROR;
                        err   <= 1'b1;
                    end
                end
                ST_RELEASE: begin
                    if (tmr_zero) begin
                        state   <= ST_RUN;
                        cpu_rst <= 1'b0;
                        done    <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pm_load_controller.sv
// tb_pm_load_controller
// Directed bench for pm_load_controller with default parameters
// (ADD_WIDTH=7, WIDTH=8, TIMEOUT=255, RST_HOLD=4).
module tb_pm_load_controller;

    logic       clk;
    logic       rst;
    logic       load_start;
    logic [6:0] load_len;
    logic [7:0] byte_in;
    logic       byte_valid;
    logic       byte_ready;
    logic       pm_wr_en;
    logic [6:0] pm_addr;
    logic [7:0] pm_wr_data;
    logic       cpu_rst;
    logic       busy;
    logic       done;
    logic       err;

    int unsigned tests;
    int unsigned failed;
    int unsigned done_cnt;
    logic [7:0]  mem [0:127];

    pm_load_controller #(
        .ADD_WIDTH (7),
        .WIDTH     (8),
        .TIMEOUT   (255),
        .RST_HOLD  (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load_start (load_start),
        .load_len   (load_len),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .pm_wr_en   (pm_wr_en),
        .pm_addr    (pm_addr),
        .pm_wr_data (pm_wr_data),
        .cpu_rst    (cpu_rst),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Program-memory image and done-pulse count, sampled mid-cycle.
    always @(negedge clk) begin
        if (pm_wr_en === 1'b1) mem[pm_addr] = pm_wr_data;
        if (done === 1'b1) done_cnt = done_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests = tests + 1;
        assert (obs === exp) else begin
            failed = failed + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        byte_valid = 1'b1;
        byte_in    = b;
        tick();
        byte_valid = 1'b0;
    endtask

    task automatic chk_wr(input string tag, input logic [6:0] a, input logic [7:0] d);
        chk({tag, "_wr_en"}, {31'd0, pm_wr_en}, 32'd1);
        chk({tag, "_addr"},  {25'd0, pm_addr},  {25'd0, a});
        chk({tag, "_data"},  {24'd0, pm_wr_data}, {24'd0, d});
    endtask

    task automatic start(input logic [6:0] len);
        load_start = 1'b1;
        load_len   = len;
        tick();
        load_start = 1'b0;
    endtask

    initial begin
        tests      = 0;
        failed     = 0;
        done_cnt   = 0;
        rst        = 1'b0;
        load_start = 1'b0;
        load_len   = '0;
        byte_in    = '0;
        byte_valid = 1'b0;
        for (int i = 0; i < 128; i++) mem[i] = 8'h00;

        // Reset state
        tick();
        tick();
        chk("rst_cpu_rst",    {31'd0, cpu_rst},    32'd1);
        chk("rst_wr_en",      {31'd0, pm_wr_en},   32'd0);
        chk("rst_byte_ready", {31'd0, byte_ready}, 32'd0);
        chk("rst_busy",       {31'd0, busy},       32'd0);
        chk("rst_done",       {31'd0, done},       32'd0);
        chk("rst_err",        {31'd0, err},        32'd0);
        chk("rst_addr",       {25'd0, pm_addr},    32'd0);
        rst = 1'b1;
        tick();
        chk("idle_cpu_rst", {31'd0, cpu_rst}, 32'd1);

        // Three back-to-back bytes
        start(7'd3);
        chk("l1_ready", {31'd0, byte_ready}, 32'd1);
        chk("l1_busy",  {31'd0, busy},       32'd1);
        byte_valid = 1'b1;
        byte_in = 8'h13; tick(); chk_wr("l1_b0", 7'd0, 8'h13);
        byte_in = 8'h05; tick(); chk_wr("l1_b1", 7'd1, 8'h05);
        byte_in = 8'hA0; tick(); chk_wr("l1_b2", 7'd2, 8'hA0);
        byte_valid = 1'b0;
        chk("l1_rel_ready", {31'd0, byte_ready}, 32'd0);
        chk("l1_rel_busy",  {31'd0, busy},       32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("l1_hold_cpu_rst", {31'd0, cpu_rst},  32'd1);
            chk("l1_hold_done",    {31'd0, done},     32'd0);
            chk("l1_hold_wr_en",   {31'd0, pm_wr_en}, 32'd0);
        end
        tick();
        chk("l1_run_cpu_rst", {31'd0, cpu_rst}, 32'd0);
        chk("l1_run_done",    {31'd0, done},    32'd1);
        chk("l1_run_busy",    {31'd0, busy},    32'd0);
        tick();
        chk("l1_done_once", {31'd0, done}, 32'd0);
        chk("l1_done_cnt",  done_cnt, 32'd1);

        // Reload from RUN; load_start during LOAD is ignored
        start(7'd4);
        chk("l2_cpu_rst", {31'd0, cpu_rst}, 32'd1);
        chk("l2_addr0",   {25'd0, pm_addr}, 32'd0);
        send(8'h11); chk_wr("l2_b0", 7'd0, 8'h11);
        send(8'h22); chk_wr("l2_b1", 7'd1, 8'h22);
        start(7'd1);
        chk("l2_ign_wr_en", {31'd0, pm_wr_en}, 32'd0);
        chk("l2_ign_busy",  {31'd0, busy},     32'd1);
        send(8'h33); chk_wr("l2_b2", 7'd2, 8'h33);
        chk("l2_still_load", {31'd0, byte_ready}, 32'd1);
        send(8'h44); chk_wr("l2_b3", 7'd3, 8'h44);
        chk("l2_rel", {31'd0, byte_ready}, 32'd0);
        chk("l2_overwrite", {24'd0, mem[0]}, 32'h11);
        repeat (4) tick();
        chk("l2_run_done", {31'd0, done}, 32'd1);

        // 10-cycle gaps complete normally
        start(7'd3);
        send(8'hC1); chk_wr("l3_b0", 7'd0, 8'hC1);
        repeat (10) tick();
        send(8'hC2); chk_wr("l3_b1", 7'd1, 8'hC2);
        repeat (10) tick();
        send(8'hC3); chk_wr("l3_b2", 7'd2, 8'hC3);
        chk("l3_err", {31'd0, err}, 32'd0);
        repeat (4) tick();
        chk("l3_run_done", {31'd0, done}, 32'd1);

        // 255-cycle gap times out; 254 does not
        start(7'd5);
        send(8'hD1); chk_wr("l4_b0", 7'd0, 8'hD1);
        repeat (254) tick();
        chk("l4_pre_err",  {31'd0, err},  32'd0);
        chk("l4_pre_busy", {31'd0, busy}, 32'd1);
        tick();
        chk("l4_err",        {31'd0, err},        32'd1);
        chk("l4_err_cpu",    {31'd0, cpu_rst},    32'd1);
        chk("l4_err_ready",  {31'd0, byte_ready}, 32'd0);
        chk("l4_err_busy",   {31'd0, busy},       32'd0);
        send(8'hEE);
        chk("l4_err_no_wr",  {31'd0, pm_wr_en},   32'd0);
        chk("l4_err_sticky", {31'd0, err},        32'd1);

        // Restart from ERROR, then reset after 2 of 5 bytes
        start(7'd5);
        chk("l5_err_clr", {31'd0, err},  32'd0);
        chk("l5_busy",    {31'd0, busy}, 32'd1);
        send(8'h55); chk_wr("l5_b0", 7'd0, 8'h55);
        send(8'h66); chk_wr("l5_b1", 7'd1, 8'h66);
        rst = 1'b0;
        send(8'h77);
        chk("l5_rst_wr_en", {31'd0, pm_wr_en}, 32'd0);
        chk("l5_rst_busy",  {31'd0, busy},     32'd0);
        chk("l5_rst_cpu",   {31'd0, cpu_rst},  32'd1);
        chk("l5_rst_addr",  {25'd0, pm_addr},  32'd0);
        rst = 1'b1;
        send(8'h78);
        chk("l5_idle_no_wr", {31'd0, pm_wr_en}, 32'd0);
        chk("l5_kept",       {24'd0, mem[1]},   32'h66);
        start(7'd2);
        send(8'h88); chk_wr("l6_b0", 7'd0, 8'h88);
        send(8'h99); chk_wr("l6_b1", 7'd1, 8'h99);
        repeat (4) tick();
        chk("l6_run_done", {31'd0, done}, 32'd1);

        // load_len = 0 means 128 bytes, no early completion
        start(7'd0);
        for (int i = 0; i < 128; i++) begin
            send(8'(i) ^ 8'h5A);
            chk_wr("l7_b", 7'(i), 8'(i) ^ 8'h5A);
            chk("l7_ready", {31'd0, byte_ready}, (i == 127) ? 32'd0 : 32'd1);
        end
        repeat (3) tick();
        chk("l7_hold_cpu", {31'd0, cpu_rst}, 32'd1);
        tick();
        chk("l7_run_done", {31'd0, done},    32'd1);
        chk("l7_run_cpu",  {31'd0, cpu_rst}, 32'd0);
        tick();
        chk("done_total", done_cnt, 32'd5);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
